// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared APU register indices, duty pattern table and envelope types
package apu_pkg;
    localparam logic [2:0] NRX0 = 3'd0;
    localparam logic [2:0] NRX1 = 3'd1;
    localparam logic [2:0] NRX2 = 3'd2;
    localparam logic [2:0] NRX3 = 3'd3;
    localparam logic [2:0] NRX4 = 3'd4;

    typedef logic [1:0] duty_t;

    typedef enum logic {
        ENV_DOWN = 1'b0,
        ENV_UP   = 1'b1
    } env_dir_t;

    // Entry 0 sits in the low byte; bit 0 of each entry is duty step 0.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b0111_1110,
        8'b1110_0001,
        8'b1000_0001,
        8'b1000_0000
    };
endpackage

// File: rtl/apu_envelope.sv
// rtl/apu_envelope.sv - volume envelope (timer, +/-1 step, saturation); shared by pulse and noise voices
module apu_envelope import apu_pkg::*; #(
    parameter int VOL_W = 4,
    parameter int PER_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             env_tick,
    input  logic [VOL_W-1:0] init_vol,
    input  env_dir_t         dir,
    input  logic [PER_W-1:0] period,
    output logic [VOL_W-1:0] volume
);
    logic [PER_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer  <= '0;
            volume <= '0;
        end else if (load) begin
            volume <= init_vol;
            timer  <= period;
        end else if (env_tick && (period != '0)) begin
            // A timer left at 0 by a zero-period trigger expires on the first tick.
            if (timer <= PER_W'(1)) begin
                timer <= period;
                if ((dir == ENV_UP) && (volume != '1))
                    volume <= volume + VOL_W'(1);
                else if ((dir == ENV_DOWN) && (volume != '0))
                    volume <= volume - VOL_W'(1);
            end else begin
                timer <= timer - PER_W'(1);
            end
        end
    end
endmodule

// File: rtl/square_channel.sv
// rtl/square_channel.sv - APU pulse voice: duty sequencer, length counter, volume envelope
// Define SQUARE_CHANNEL_SWEEP_EN to add the frequency sweep unit.
module square_channel import apu_pkg::*; #(
    parameter int FREQ_W      = 11,
    parameter int LEN_W       = 6,
    parameter int VOL_W       = 4,
    parameter int ENV_PER_W   = 3,
    parameter int SWEEP_PER_W = 3
) (
    input  logic             apu_clk,
    input  logic             napu_reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             tone_tick,
    input  logic             len_tick,
    input  logic             sweep_tick,
    input  logic             env_tick,
    output logic [VOL_W-1:0] ch_out,
    output logic             ch_active,
    output logic             dac_en
);
    logic              wr_nrx1, wr_nrx2, wr_nrx3, wr_nrx4, trigger;
    duty_t             duty;
    logic              len_en;
    logic [7:0]        nrx2;
    logic [FREQ_W-1:0] freq, period_cnt;
    logic [10:0]       freq_wide;
    logic [2:0]        step;
    logic [LEN_W-1:0]  len_cnt;
    logic              len_expired, len_wrap, dac_next;
    logic [VOL_W-1:0]  volume;
    logic              sweep_kill, sweep_freq_we;
    logic [FREQ_W-1:0] sweep_freq;

    assign wr_nrx1   = wr_en && (wr_addr == NRX1);
    assign wr_nrx2   = wr_en && (wr_addr == NRX2);
    assign wr_nrx3   = wr_en && (wr_addr == NRX3);
    assign wr_nrx4   = wr_en && (wr_addr == NRX4);
    assign trigger   = wr_nrx4 && wr_data[7];
    assign freq_wide = 11'(freq);
    assign dac_en    = |nrx2[7:3];
    // Look through a pending NRx2 write so the DAC-off clear lands on the write edge.
    assign dac_next  = wr_nrx2 ? (|wr_data[7:3]) : dac_en;
    assign len_wrap  = len_tick && len_en && ch_active && (len_cnt == '1) && !trigger;

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset) begin
            duty   <= '0;
            len_en <= 1'b0;
            nrx2   <= '0;
            freq   <= '0;
        end else begin
            if (wr_nrx1) duty <= duty_t'(wr_data[7:6]);
            if (wr_nrx2) nrx2 <= wr_data;
            if (wr_nrx3) begin
                freq <= FREQ_W'({freq_wide[10:8], wr_data});
            end else if (wr_nrx4) begin
                freq   <= FREQ_W'({wr_data[2:0], freq_wide[7:0]});
                len_en <= wr_data[6];
            end else if (sweep_freq_we) begin
                freq <= sweep_freq;
            end
        end
    end

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset) begin
            period_cnt <= '0;
            step       <= '0;
        end else if (trigger) begin
            period_cnt <= freq;
        end else if (tone_tick) begin
            if (period_cnt == '1) begin
                period_cnt <= freq;
                step       <= step + 3'd1;
            end else begin
                period_cnt <= period_cnt + FREQ_W'(1);
            end
        end
    end

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset) begin
            len_cnt     <= '0;
            len_expired <= 1'b0;
        end else if (wr_nrx1) begin
            len_cnt     <= LEN_W'(wr_data[5:0]);
            len_expired <= 1'b0;
        end else if (trigger) begin
            if (len_expired) begin
                len_cnt     <= '0;
                len_expired <= 1'b0;
            end
        end else if (len_tick && len_en && ch_active) begin
            len_cnt <= len_cnt + LEN_W'(1);
            if (len_cnt == '1) len_expired <= 1'b1;
        end
    end

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset)
            ch_active <= 1'b0;
        else if (!dac_next)
            ch_active <= 1'b0;
        else if (trigger)
            ch_active <= dac_en;
        else if (len_wrap || sweep_kill)
            ch_active <= 1'b0;
    end

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset)
            ch_out <= '0;
        else
            ch_out <= (ch_active && DUTY_TABLE[duty][step]) ? volume : '0;
    end

    apu_envelope #(
        .VOL_W (VOL_W),
        .PER_W (ENV_PER_W)
    ) u_envelope (
        .clk      (apu_clk),
        .rst_n    (napu_reset),
        .load     (trigger),
        .env_tick (env_tick),
        .init_vol (VOL_W'(nrx2[7:4])),
        .dir      (env_dir_t'(nrx2[3])),
        .period   (ENV_PER_W'(nrx2[2:0])),
        .volume   (volume)
    );

`ifdef SQUARE_CHANNEL_SWEEP_EN
    logic                   wr_nrx0, sweep_expire, sweep_ovf, check_pending;
    logic [6:0]             nrx0;
    logic [SWEEP_PER_W-1:0] sweep_per, sweep_timer;
    logic [FREQ_W-1:0]      shadow;
    logic [FREQ_W:0]        sweep_delta, sweep_new;

    assign wr_nrx0      = wr_en && (wr_addr == NRX0);
    assign sweep_per    = SWEEP_PER_W'(nrx0[6:4]);
    assign sweep_delta  = {1'b0, shadow} >> nrx0[2:0];
    // delta never exceeds shadow, so the negate path cannot wrap below zero.
    assign sweep_new    = nrx0[3] ? ({1'b0, shadow} - sweep_delta) : ({1'b0, shadow} + sweep_delta);
    assign sweep_ovf    = sweep_new[FREQ_W];
    assign sweep_expire = sweep_tick && (sweep_per != '0) && (sweep_timer <= SWEEP_PER_W'(1)) && !trigger;
    assign sweep_kill   = sweep_ovf && (check_pending || sweep_expire);
    assign sweep_freq_we = sweep_expire && !sweep_ovf && (nrx0[2:0] != 3'd0);
    assign sweep_freq   = sweep_new[FREQ_W-1:0];

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset) begin
            nrx0          <= '0;
            shadow        <= '0;
            sweep_timer   <= '0;
            check_pending <= 1'b0;
        end else begin
            if (wr_nrx0) nrx0 <= wr_data[6:0];
            if (trigger) begin
                shadow        <= freq;
                sweep_timer   <= sweep_per;
                check_pending <= (nrx0[2:0] != 3'd0);
            end else begin
                check_pending <= sweep_freq_we;
                if (sweep_tick && (sweep_per != '0))
                    sweep_timer <= (sweep_timer <= SWEEP_PER_W'(1)) ? sweep_per : sweep_timer - SWEEP_PER_W'(1);
                if (sweep_freq_we) shadow <= sweep_new[FREQ_W-1:0];
            end
        end
    end
`else
    logic unused_sweep;
    assign sweep_kill    = 1'b0;
    assign sweep_freq_we = 1'b0;
    assign sweep_freq    = '0;
    assign unused_sweep  = ^{sweep_tick, wr_data[5:3], (SWEEP_PER_W > 0)};
`endif
endmodule
